flex_rx_deser: RTL and testbench
================================

# flex_rx_deser

Parametrised serial-to-parallel receive deserialiser with a bit counter, word framing, and an output word FIFO with valid/ready handshake. It sits between the receive bit-timing logic, which supplies `shift_enable` once per sampled bit, and the packet/byte consumer. It replaces the fixed 8-bit receive shift register. Over the fixed register it adds configurable word width and shift direction, automatic word-complete detection, buffering of completed words, overrun reporting, and optional parity checking.

## Interface
- NUM_BITS, 8: data bits per word; legal range 2..32.
- SHIFT_MSB, 0: 0 = first received bit lands in bit 0 (LSB-first line); 1 = first received bit lands in bit NUM_BITS-1.
- FIFO_DEPTH, 2: completed-word buffer entries; must be a power of two, at least 2.
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- shift_enable  in  1  sample `serial_in` this cycle.
- serial_in  in  1  received serial bit.
- clear  in  1  synchronous flush: counter, shift register, FIFO and overrun.
- out_ready  in  1  consumer accepts the head word.
- out_valid  out  1  FIFO not empty.
- parallel_out  out  NUM_BITS  head word; all zeros when empty.
- parity_error  out  1  parity flag stored with the head word; 0 when empty.
- overrun  out  1  sticky: a completed word was dropped.
- bit_count  out  $clog2(NUM_BITS+1)  bits received in the current word.

## Operation
- **Reset values:**
  - Shift register is all ones (idle line).
  - bit_count=0, out_valid=0, parallel_out=0, parity_error=0, overrun=0.
  - FIFO pointers are zero.
- **Shift:**
  - On a clock edge with shift_enable=1 and clear=0, `serial_in` enters the shift register.
  - SHIFT_MSB=0: the bit enters at the MSB and contents move toward the LSB.
  - SHIFT_MSB=1: the bit enters at the LSB and contents move toward the MSB.
- **Framing:**
  - bit_count increments on each shift.
  - When a shift occurs with bit_count = WORD_LEN-1, the assembled word, including the bit being shifted in, is pushed to the FIFO on that same edge, and bit_count wraps to 0.
  - WORD_LEN = NUM_BITS, or NUM_BITS+1 when parity is enabled.
- **Handshake:**
  - A pop occurs on an edge where out_valid=1 and out_ready=1.
  - parallel_out and parity_error always show the head entry.
  - out_ready is ignored when empty.
- **Full FIFO with a push:**
  - If a pop occurs on the same edge, the push is accepted and occupancy is unchanged.
  - Otherwise the word is dropped and overrun is set.
  - FIFO contents are unchanged.
- **Empty FIFO with a push and out_ready=1:** no pop occurs. The word is visible on the next cycle.
- **overrun:** stays set until clear or reset.
- **clear:**
  - Takes priority over shift_enable and the pop.
  - On the edge: bit_count=0, shift register all ones, FIFO emptied, overrun=0.
- **Reset mid-word or mid-handshake:** all state returns to its reset value immediately (asynchronous). The partial word is discarded.

## Timing
- Latency: the final shift_enable edge of a word is edge k; out_valid=1 and parallel_out are valid after edge k. Latency is 0 cycles after the final sample.
- Back-to-back words: shift_enable may be high every cycle; sustained throughput is one word per WORD_LEN cycles.
- A word popped on edge k is replaced by the next entry after edge k.
- bit_count, overrun and out_valid are registered outputs. parallel_out and parity_error come from the registered FIFO head via a read mux.

## Configuration
- Macro: FLEX_RX_DESER_PARITY_EN.
- **Defined:**
  - WORD_LEN = NUM_BITS+1; the last received bit is an even-parity bit and is not placed in parallel_out.
  - On a push, the XOR of the data bits and the parity bit is stored with the word; a result of 1 sets parity_error for that entry.
  - Parity errors never drop a word.
- **Undefined:**
  - WORD_LEN = NUM_BITS.
  - parity_error is tied to 0 and the FIFO stores no parity bit.
  - The port list is identical in both builds.

## Structure
- Package flex_rx_deser_pkg holds:
  - SR_IDLE_VALUE bit constant (1'b1).
  - Even-parity select constant.
  - A count_width function returning $clog2(n+1).
  - The fifo_entry_t field layout description (data plus parity flag).
- One sub-module, flex_rx_deser_fifo:
  - Parametrised by entry width and depth.
  - Has push, pop, full, empty and head output.
  - Implements the simultaneous push/pop-when-full rule internally.
- The top level holds the shift register, bit counter, parity logic and overrun flag.

## Test plan
- **LSB-first:** NUM_BITS=8, SHIFT_MSB=0; shift 1,0,1,0,1,1,0,0 on consecutive cycles with out_ready=0 -> after the 8th edge, out_valid=1, parallel_out=0x35, bit_count=0.
- **MSB-first:** SHIFT_MSB=1; same bit sequence -> parallel_out=0xAC.
- **Overrun:** FIFO_DEPTH=2, out_ready=0; send words 0x11, 0x22, 0x33 -> overrun=1 after the 24th shift and head=0x11. Raising out_ready yields 0x11 then 0x22, then out_valid=0. overrun stays 1 until clear.
- **Push/pop when full:** FIFO full with 0x11 and 0x22; complete 0x44 on the same edge out_ready=1 -> overrun=0, and the subsequent pops yield 0x22 then 0x44.
- **Clear mid-word and reset:**
  - Shift 5 bits, pulse clear, then send 0x5A -> parallel_out=0x5A.
  - Drop n_rst mid-word -> bit_count=0, out_valid=0, parallel_out=0 without a clock edge.
- **Parity (macro defined):**
  - Send 0x35 with parity bit 0 -> parity_error=0.
  - Send 0x35 with parity bit 1 -> parity_error=1 with head 0x35.

Source files
------------

// File: rtl/flex_rx_deser_pkg.sv
// Shared constants and helpers for the flex_rx_deser receive deserialiser.
// FIFO entry layout is {parity_flag, data[NUM_BITS-1:0]}, with the flag present only when FLEX_RX_DESER_PARITY_EN is defined.
package flex_rx_deser_pkg;

  localparam logic SR_IDLE_VALUE = 1'b1;
  // XOR over data plus parity bit that marks a good word (even parity).
  localparam logic PARITY_EVEN   = 1'b0;

`ifdef FLEX_RX_DESER_PARITY_EN
  localparam int ENTRY_PAR_W = 1;
`else
  localparam int ENTRY_PAR_W = 0;
`endif

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int entry_width(input int num_bits);
    return num_bits + ENTRY_PAR_W;
  endfunction

endpackage

// File: rtl/flex_rx_deser_fifo.sv
// Completed-word FIFO; a push into a full FIFO is accepted only when a pop happens on the same edge.
module flex_rx_deser_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // When full, the write slot is the one being popped, so the old value leaves as the new one lands.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/flex_rx_deser.sv
// Serial-to-parallel receive deserialiser with word framing, output FIFO and sticky overrun.
// Optional even-parity checking is enabled by defining FLEX_RX_DESER_PARITY_EN.
module flex_rx_deser
  import flex_rx_deser_pkg::*;
#(
  parameter int NUM_BITS   = 8,
  parameter int SHIFT_MSB  = 0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           shift_enable,
  input  logic                           serial_in,
  input  logic                           clear,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [NUM_BITS-1:0]            parallel_out,
  output logic                           parity_error,
  output logic                           overrun,
  output logic [count_width(NUM_BITS)-1:0] bit_count
);
  localparam int WORD_LEN = NUM_BITS + ENTRY_PAR_W;
  localparam int CNT_W    = count_width(NUM_BITS);
  localparam int ENTRY_W  = entry_width(NUM_BITS);

  logic [WORD_LEN-1:0] sr_q, sr_next;
  logic [CNT_W-1:0]    cnt_q;
  logic                overrun_q;
  logic                word_done, pop, full, empty;
  logic [NUM_BITS-1:0] word_data;
  logic [ENTRY_W-1:0]  push_entry, head_entry;

  // The shift register spans the whole frame, so a trailing parity bit sits outside the data slice.
  generate
    if (SHIFT_MSB != 0) begin : g_msb_first
      assign sr_next   = {sr_q[WORD_LEN-2:0], serial_in};
      assign word_data = sr_next[WORD_LEN-1 -: NUM_BITS];
    end else begin : g_lsb_first
      assign sr_next   = {serial_in, sr_q[WORD_LEN-1:1]};
      assign word_data = sr_next[NUM_BITS-1:0];
    end
  endgenerate

  assign word_done = shift_enable && !clear && (cnt_q == CNT_W'(WORD_LEN-1));
  assign pop       = out_ready && !empty;

`ifdef FLEX_RX_DESER_PARITY_EN
  assign push_entry   = {(^sr_next) ^ PARITY_EVEN, word_data};
  assign parity_error = head_entry[ENTRY_W-1];
`else
  assign push_entry   = word_data;
  assign parity_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr_q      <= {WORD_LEN{SR_IDLE_VALUE}};
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else if (clear) begin
      sr_q      <= {WORD_LEN{SR_IDLE_VALUE}};
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (shift_enable) begin
        sr_q  <= sr_next;
        cnt_q <= word_done ? '0 : cnt_q + CNT_W'(1);
      end
      if (word_done && full && !pop) overrun_q <= 1'b1;
    end
  end

  flex_rx_deser_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (clear),
    .push      (word_done),
    .pop       (pop),
    .push_data (push_entry),
    .full      (full),
    .empty     (empty),
    .head      (head_entry)
  );

  assign out_valid    = !empty;
  assign parallel_out = head_entry[NUM_BITS-1:0];
  assign overrun      = overrun_q;
  assign bit_count    = cnt_q;

endmodule

// File: tb/tb_flex_rx_deser.sv
// Directed bench for flex_rx_deser: an LSB-first and an MSB-first instance share stimulus; a queue model scores pops.
module tb_flex_rx_deser;
  localparam int DEPTH = 2;
`ifdef FLEX_RX_DESER_PARITY_EN
  localparam int WL = 9;
`else
  localparam int WL = 8;
`endif

  typedef struct {
    logic [7:0] d;
    logic       p;
  } ent_t;

  logic       clk = 1'b0;
  logic       n_rst, shift_enable, serial_in, clear, out_ready;
  logic       lsb_valid, lsb_perr, lsb_ovr, msb_valid, msb_perr, msb_ovr;
  logic [7:0] lsb_data, msb_data;
  logic [3:0] lsb_cnt, msb_cnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t exp_q[$];
  logic exp_ovr = 1'b0;

  always #5 clk = ~clk;

  flex_rx_deser #(.NUM_BITS(8), .SHIFT_MSB(0), .FIFO_DEPTH(DEPTH)) u_lsb (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .serial_in(serial_in),
    .clear(clear), .out_ready(out_ready), .out_valid(lsb_valid), .parallel_out(lsb_data),
    .parity_error(lsb_perr), .overrun(lsb_ovr), .bit_count(lsb_cnt));

  flex_rx_deser #(.NUM_BITS(8), .SHIFT_MSB(1), .FIFO_DEPTH(DEPTH)) u_msb (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .serial_in(serial_in),
    .clear(clear), .out_ready(out_ready), .out_valid(msb_valid), .parallel_out(msb_data),
    .parity_error(msb_perr), .overrun(msb_ovr), .bit_count(msb_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs are already driven; score the edge against the model, then advance to 1 ns past it.
  task automatic tick(input logic push_now, input logic [7:0] d, input logic p);
    logic pop_now;
    pop_now = out_ready && !clear && (exp_q.size() > 0);
    if (clear) begin
      exp_q.delete();
      exp_ovr = 1'b0;
    end else begin
      if (pop_now) begin
        chk("pop_valid",  32'(lsb_valid), 32'd1);
        chk("pop_data",   32'(lsb_data),  32'(exp_q[0].d));
        chk("pop_parity", 32'(lsb_perr),  32'(exp_q[0].p));
        void'(exp_q.pop_front());
      end
      if (push_now) begin
        if (exp_q.size() < DEPTH) exp_q.push_back('{d: d, p: p});
        else exp_ovr = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    shift_enable = 1'b0;
    out_ready    = rdy;
    tick(1'b0, 8'h00, 1'b0);
  endtask

  // Data goes out LSB first; with parity enabled a trailing even-parity bit (optionally corrupted) follows.
  task automatic send_word(input logic [7:0] d, input logic bad, input logic rdy_last, input logic rdy_all);
    for (int i = 0; i < WL; i++) begin
      shift_enable = 1'b1;
      serial_in    = (i < 8) ? d[i] : ((^d) ^ bad);
      out_ready    = rdy_all || (rdy_last && (i == WL-1));
      tick(i == WL-1, d, bad);
    end
    shift_enable = 1'b0;
    out_ready    = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; shift_enable = 1'b0; serial_in = 1'b0; clear = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count",  32'(lsb_cnt),   32'd0);
    chk("rst_valid",  32'(lsb_valid), 32'd0);
    chk("rst_data",   32'(lsb_data),  32'd0);
    chk("rst_parity", 32'(lsb_perr),  32'd0);
    chk("rst_ovr",    32'(lsb_ovr),   32'd0);
    n_rst = 1'b1;
    idle(1'b0);

    // LSB-first and MSB-first framing of 1,0,1,0,1,1,0,0
    send_word(8'h35, 1'b0, 1'b0, 1'b0);
    chk("lsb_valid", 32'(lsb_valid), 32'd1);
    chk("lsb_data",  32'(lsb_data),  32'h35);
    chk("lsb_count", 32'(lsb_cnt),   32'd0);
    chk("msb_data",  32'(msb_data),  32'hAC);
    idle(1'b1);
    chk("drained", 32'(lsb_valid), 32'd0);

    // Overrun with the FIFO full
    send_word(8'h11, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b0);
    chk("ovr_before", 32'(lsb_ovr), 32'(exp_ovr));
    send_word(8'h33, 1'b0, 1'b0, 1'b0);
    chk("ovr_set",  32'(lsb_ovr),  32'(exp_ovr));
    chk("ovr_set1", 32'(lsb_ovr),  32'd1);
    chk("ovr_head", 32'(lsb_data), 32'h11);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("ovr_empty",  32'(lsb_valid), 32'd0);
    chk("ovr_sticky", 32'(lsb_ovr),   32'd1);
    clear = 1'b1;
    idle(1'b0);
    clear = 1'b0;
    chk("ovr_clear", 32'(lsb_ovr), 32'd0);

    // Push into a full FIFO on the same edge as a pop
    send_word(8'h11, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b0);
    send_word(8'h44, 1'b0, 1'b1, 1'b0);
    chk("pp_ovr",  32'(lsb_ovr),  32'd0);
    chk("pp_head", 32'(lsb_data), 32'h22);
    idle(1'b1);
    idle(1'b1);
    chk("pp_empty", 32'(lsb_valid), 32'd0);

    // Clear mid-word, then a word arriving into an empty FIFO with out_ready held high
    for (int i = 0; i < 5; i++) begin
      shift_enable = 1'b1;
      serial_in    = 1'($urandom_range(0, 1));
      tick(1'b0, 8'h00, 1'b0);
    end
    chk("mid_count", 32'(lsb_cnt), 32'd5);
    shift_enable = 1'b1;
    clear = 1'b1;
    tick(1'b0, 8'h00, 1'b0);
    clear = 1'b0;
    chk("clr_count", 32'(lsb_cnt), 32'd0);
    send_word(8'h5A, 1'b0, 1'b0, 1'b1);
    chk("clr_valid", 32'(lsb_valid), 32'd1);
    chk("clr_data",  32'(lsb_data),  32'h5A);
    idle(1'b1);

    // Asynchronous reset in the middle of a word with a word pending
    send_word(8'h77, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      shift_enable = 1'b1;
      serial_in    = 1'b1;
      tick(1'b0, 8'h00, 1'b0);
    end
    shift_enable = 1'b0;
    #2;
    n_rst = 1'b0;
    exp_q.delete();
    exp_ovr = 1'b0;
    #1;
    chk("arst_count", 32'(lsb_cnt),   32'd0);
    chk("arst_valid", 32'(lsb_valid), 32'd0);
    chk("arst_data",  32'(lsb_data),  32'd0);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back words with shift_enable high every cycle
    send_word(8'hC3, 1'b0, 1'b0, 1'b0);
    send_word(8'h0F, 1'b0, 1'b0, 1'b0);
    chk("b2b_head", 32'(lsb_data), 32'hC3);
    idle(1'b1);
    idle(1'b1);
    chk("b2b_empty", 32'(lsb_valid), 32'd0);

`ifdef FLEX_RX_DESER_PARITY_EN
    send_word(8'h35, 1'b0, 1'b0, 1'b0);
    chk("par_good", 32'(lsb_perr), 32'd0);
    idle(1'b1);
    send_word(8'h35, 1'b1, 1'b0, 1'b0);
    chk("par_bad",      32'(lsb_perr), 32'd1);
    chk("par_bad_data", 32'(lsb_data), 32'h35);
    idle(1'b1);
`else
    send_word(8'h35, 1'b0, 1'b0, 1'b0);
    chk("par_tied", 32'(lsb_perr), 32'd0);
    idle(1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
